// File: rtl/dp_ram_tdp_gen2.sv
// Parametrised true dual-port RAM with per-port write modes, optional output
// register, deterministic same-address collision handling and a clear sweeper.
module dp_ram_tdp_gen2 #(
    parameter int unsigned      DEPTH          = 1024,
    parameter int unsigned      WIDTH          = 32,
    parameter int unsigned      BYTE_W         = 8,
    parameter int unsigned      ADDR_WIDTH     = 10,
    parameter int unsigned      WRITE_MODE_A   = 0,
    parameter int unsigned      WRITE_MODE_B   = 0,
    parameter int unsigned      OUT_REG        = 0,
    parameter int unsigned      CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    output logic                    init_busy,
    input  logic                    ena,
    input  logic                    wea,
    input  logic [WIDTH/BYTE_W-1:0] bea,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [WIDTH-1:0]        dina,
    output logic [WIDTH-1:0]        douta,
    output logic                    dvalida,
    output logic                    collision_a,
    input  logic                    enb,
    input  logic                    web,
    input  logic [WIDTH/BYTE_W-1:0] beb,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [WIDTH-1:0]        dinb,
    output logic [WIDTH-1:0]        doutb,
    output logic                    dvalidb,
    output logic                    collision_b
);

    localparam int unsigned NB = WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy;

    logic [WIDTH-1:0]        mem_q [DEPTH];

    logic                    acc_a, acc_b;
    logic                    wr_a, wr_b;
    logic                    rd_a, rd_b;
    logic                    same_addr;
    logic                    ww_coll;
    logic                    col_a, col_b;
    logic [WIDTH-1:0]        old_a, old_b;
    logic [WIDTH-1:0]        new_a, new_b;

    logic [WIDTH-1:0]        dout1a_q, dout1a_d;
    logic                    dv1a_q, dv1a_d;
    logic                    col1a_q;
    logic [WIDTH-1:0]        dout1b_q, dout1b_d;
    logic                    dv1b_q, dv1b_d;
    logic                    col1b_q;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_READY;
            end
            cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // Counter parks on the last address instead of wrapping.
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign init_busy = busy;

    // ------------------------------------------------------------------
    // Request qualification and collision detection
    // ------------------------------------------------------------------
    assign acc_a     = ena & ~busy;
    assign acc_b     = enb & ~busy;
    assign wr_a      = acc_a & wea;
    assign wr_b      = acc_b & web;
    assign rd_a      = acc_a & ~wea;
    assign rd_b      = acc_b & ~web;
    assign same_addr = (addr_a == addr_b);
    assign ww_coll   = wr_a & wr_b & same_addr;
    assign col_a     = ww_coll | (rd_a & wr_b & same_addr);
    assign col_b     = ww_coll | (rd_b & wr_a & same_addr);

    assign old_a = mem_q[addr_a];
    assign old_b = mem_q[addr_b];

    // On a write-write collision both ports compute the same final word
    // (A wins shared lanes), so both array writes below are identical.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (bea[i]) begin
                new_a[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
            end else if (ww_coll && beb[i]) begin
                new_a[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
            end
            if (ww_coll && bea[i]) begin
                new_b[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
            end else if (beb[i]) begin
                new_b[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array (no reset; initialised by the clear sweep)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= CLEAR_VALUE;
        end else begin
            if (wr_b) begin
                mem_q[addr_b] <= new_b;
            end
            if (wr_a) begin
                mem_q[addr_a] <= new_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // First output stage: per-port write-mode selection
    // ------------------------------------------------------------------
    always_comb begin
        dout1a_d = dout1a_q;
        dv1a_d   = 1'b0;
        if (rd_a) begin
            dout1a_d = old_a;
            dv1a_d   = 1'b1;
        end else if (wr_a) begin
            if (WRITE_MODE_A == 0) begin
                dout1a_d = new_a;
                dv1a_d   = 1'b1;
            end else if (WRITE_MODE_A == 1) begin
                dout1a_d = old_a;
                dv1a_d   = 1'b1;
            end
        end
    end

    always_comb begin
        dout1b_d = dout1b_q;
        dv1b_d   = 1'b0;
        if (rd_b) begin
            dout1b_d = old_b;
            dv1b_d   = 1'b1;
        end else if (wr_b) begin
            if (WRITE_MODE_B == 0) begin
                dout1b_d = new_b;
                dv1b_d   = 1'b1;
            end else if (WRITE_MODE_B == 1) begin
                dout1b_d = old_b;
                dv1b_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1a_q <= '0;
            dv1a_q   <= 1'b0;
            col1a_q  <= 1'b0;
            dout1b_q <= '0;
            dv1b_q   <= 1'b0;
            col1b_q  <= 1'b0;
        end else begin
            dout1a_q <= dout1a_d;
            dv1a_q   <= dv1a_d;
            col1a_q  <= col_a;
            dout1b_q <= dout1b_d;
            dv1b_q   <= dv1b_d;
            col1b_q  <= col_b;
        end
    end

    // ------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] dout2a_q, dout2b_q;
        logic             dv2a_q, dv2b_q;
        logic             col2a_q, col2b_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout2a_q <= '0;
                dv2a_q   <= 1'b0;
                col2a_q  <= 1'b0;
                dout2b_q <= '0;
                dv2b_q   <= 1'b0;
                col2b_q  <= 1'b0;
            end else begin
                if (dv1a_q) begin
                    dout2a_q <= dout1a_q;
                end
                if (dv1b_q) begin
                    dout2b_q <= dout1b_q;
                end
                dv2a_q  <= dv1a_q;
                col2a_q <= col1a_q;
                dv2b_q  <= dv1b_q;
                col2b_q <= col1b_q;
            end
        end

        assign douta       = dout2a_q;
        assign dvalida     = dv2a_q;
        assign collision_a = col2a_q;
        assign doutb       = dout2b_q;
        assign dvalidb     = dv2b_q;
        assign collision_b = col2b_q;
    end else begin : g_noreg
        assign douta       = dout1a_q;
        assign dvalida     = dv1a_q;
        assign collision_a = col1a_q;
        assign doutb       = dout1b_q;
        assign dvalidb     = dv1b_q;
        assign collision_b = col1b_q;
    end

endmodule
